pc_unit: RTL

//   Registered program-counter unit; parametrised successor to the combinational PC+4 adder.

---
 rtl/pc_unit_if.sv | 25 ++
 rtl/pc_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch-PC control/status bundle between the pipeline control logic (master)
// and the program-counter unit (slave).
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcplus4;
  logic            flush;
  logic            misalign;
  logic            pending;

  modport master (
    output stall, redirect_valid, redirect_target, trap,
    input  pc, pcplus4, flush, misalign, pending
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap,
    output pc, pcplus4, flush, misalign, pending
  );
endinterface

// File: rtl/pc_unit.sv
// Registered fetch program counter: sequential advance by STEP, stall,
// redirects buffered across stalls, trap entry and misaligned-target rejection.
module pc_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter int unsigned    STEP         = 4,
  parameter logic [XLEN-1:0] ALIGN_MASK   = 'h3,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            pending_q, pending_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pc_next_seq;
  logic            target_misaligned;

  // Sequential successor; wraps silently modulo 2^XLEN.
  assign pc_next_seq       = pc_q + XLEN'(STEP);
  assign target_misaligned = (bus.redirect_target & ALIGN_MASK) != '0;

  // Next-state selection, first matching rule wins.
  always_comb begin
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pending_d     = pending_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    if (bus.trap) begin
      pc_d      = TRAP_VECTOR;
      flush_d   = 1'b1;
      pending_d = 1'b0;
    end else if (bus.redirect_valid && target_misaligned) begin
      // Bad target is rejected even when stalled and kills any buffered redirect.
      pc_d       = TRAP_VECTOR;
      flush_d    = 1'b1;
      misalign_d = 1'b1;
      pending_d  = 1'b0;
    end else if (bus.redirect_valid && !bus.stall) begin
      pc_d      = bus.redirect_target;
      flush_d   = 1'b1;
      pending_d = 1'b0;
    end else if (bus.redirect_valid) begin
      // Newest redirect wins over an older buffered one.
      pend_target_d = bus.redirect_target;
      pending_d     = 1'b1;
    end else if (pending_q && !bus.stall) begin
      pc_d      = pend_target_q;
      pending_d = 1'b0;
      flush_d   = 1'b1;
    end else if (!bus.stall) begin
      pc_d = pc_next_seq;
    end
  end

  // State registers; reset discards any buffered redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      pend_target_q <= '0;
      pending_q     <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pending_q     <= pending_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pcplus4  = pc_next_seq;
  assign bus.flush    = flush_q;
  assign bus.misalign = misalign_q;
  assign bus.pending  = pending_q;

endmodule
